// File: rtl/mac_recv_filt.sv
// Ethernet rx header parser: destination filtering, optional single VLAN tag strip,
// ARP/IPv4 classification and saturating frame/drop statistics.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_WAIT    | after reset, ignore bytes until an inter-frame gap is seen
//   S_DST     | 6 destination bytes, narrowing the bcast/ucast/mcast flags
//   S_SRC     | 6 source bytes shifted into temp_mac, address verdict
//   S_TYPE    | 2 ethertype bytes (ARP, IPv4 or 802.1Q tag)
//   S_TCI     | 2 tag control bytes, VID captured
//   S_TYPE2   | 2 inner ethertype bytes, a second tag is rejected
//   S_PAYLOAD | frame accepted, payload flowing until rx_enable drops
//   S_ERROR   | frame dropped, discard until rx_enable drops
module mac_recv_filt #(
  parameter int NUM_MCAST = 2,
  parameter int VLAN_EN   = 1,
  parameter int CNT_W     = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   rx_enable,
  input  logic [7:0]             data,
  input  logic [47:0]            local_mac,
  input  logic [48*NUM_MCAST-1:0] mcast_mac,
  input  logic [NUM_MCAST-1:0]   mcast_en,
  input  logic                   promisc,
  output logic                   active,
  output logic                   broadcast,
  output logic                   multicast,
  output logic                   is_arp,
  output logic                   is_ip,
  output logic                   vlan_valid,
  output logic [11:0]            vlan_id,
  output logic [47:0]            remote_mac,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic [CNT_W-1:0]       drop_addr_cnt,
  output logic [CNT_W-1:0]       drop_proto_cnt
);

  typedef enum logic [2:0] {
    S_WAIT, S_DST, S_SRC, S_TYPE, S_TCI, S_TYPE2, S_PAYLOAD, S_ERROR
  } state_t;

  localparam bit VLAN_ON = (VLAN_EN != 0);

  state_t                 state, state_nxt;
  logic [2:0]             byte_cnt, cnt_nxt;
  logic                   cnt_tc;
  logic                   bcast, ucast;
  logic [NUM_MCAST-1:0]   mcast;
  logic                   bcast_nxt, ucast_nxt;
  logic [NUM_MCAST-1:0]   mcast_nxt;
  logic                   accept_nxt;
  logic                   dst_ok, mcast_hit;
  logic [47:0]            temp_mac;
  logic [7:0]             type_hi;
  logic [11:0]            vid_tmp;
  logic [15:0]            ethertype;
  logic [7:0]             local_byte;

  logic frame_start, dst_step, dst_last, src_step;
  logic type_hi_ld, tci_hi_ld, tci_lo_ld;
  logic take, drop_addr, drop_proto;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign cnt_tc    = (byte_cnt == 3'd0);
  assign ethertype = {type_hi, data};
  assign active    = rx_enable & (state == S_PAYLOAD);

  // The down-counter doubles as the byte lane index: count 5 selects bits [47:40].
  assign local_byte = 8'(local_mac >> {byte_cnt, 3'b000});

  always_comb begin
    mcast_nxt = '0;
    bcast_nxt = bcast & (data == 8'hFF);
    ucast_nxt = ucast & (data == local_byte);
    for (int k = 0; k < NUM_MCAST; k++) begin
      mcast_nxt[k] = mcast[k] & (data == 8'(mcast_mac[48*k +: 48] >> {byte_cnt, 3'b000}));
    end
    accept_nxt = bcast_nxt | ucast_nxt | (|(mcast_nxt & mcast_en)) | promisc;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_WAIT;
      byte_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = byte_cnt;
    frame_start = 1'b0;
    dst_step    = 1'b0;
    dst_last    = 1'b0;
    src_step    = 1'b0;
    type_hi_ld  = 1'b0;
    tci_hi_ld   = 1'b0;
    tci_lo_ld   = 1'b0;
    take        = 1'b0;
    drop_addr   = 1'b0;
    drop_proto  = 1'b0;
    if (!rx_enable) begin
      state_nxt   = S_DST;
      cnt_nxt     = 3'd5;
      frame_start = 1'b1;
    end else begin
      case (state)
        S_WAIT: ;
        S_DST: begin
          dst_step = 1'b1;
          if (cnt_tc) begin
            dst_last  = 1'b1;
            state_nxt = S_SRC;
            cnt_nxt   = 3'd5;
          end else begin
            cnt_nxt = byte_cnt - 3'd1;
          end
        end
        S_SRC: begin
          src_step = 1'b1;
          if (cnt_tc) begin
            if (dst_ok) begin
              state_nxt = S_TYPE;
              cnt_nxt   = 3'd1;
            end else begin
              state_nxt = S_ERROR;
              drop_addr = 1'b1;
            end
          end else begin
            cnt_nxt = byte_cnt - 3'd1;
          end
        end
        S_TYPE, S_TYPE2: begin
          if (!cnt_tc) begin
            type_hi_ld = 1'b1;
            cnt_nxt    = 3'd0;
            // Only 08xx and 81xx can ever be accepted, so reject the rest early.
            if (data != 8'h08 && data != 8'h81) begin
              state_nxt  = S_ERROR;
              drop_proto = 1'b1;
            end
          end else if (ethertype == 16'h0806 || ethertype == 16'h0800) begin
            state_nxt = S_PAYLOAD;
            take      = 1'b1;
          end else if (ethertype == 16'h8100 && VLAN_ON && state == S_TYPE) begin
            state_nxt = S_TCI;
            cnt_nxt   = 3'd1;
          end else begin
            state_nxt  = S_ERROR;
            drop_proto = 1'b1;
          end
        end
        S_TCI: begin
          if (!cnt_tc) begin
            tci_hi_ld = 1'b1;
            cnt_nxt   = 3'd0;
          end else begin
            tci_lo_ld = 1'b1;
            state_nxt = S_TYPE2;
            cnt_nxt   = 3'd1;
          end
        end
        S_PAYLOAD, S_ERROR: ;
        default: state_nxt = S_WAIT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bcast          <= 1'b0;
      ucast          <= 1'b0;
      mcast          <= '0;
      dst_ok         <= 1'b0;
      mcast_hit      <= 1'b0;
      temp_mac       <= '0;
      type_hi        <= '0;
      vid_tmp        <= '0;
      broadcast      <= 1'b0;
      multicast      <= 1'b0;
      is_arp         <= 1'b0;
      is_ip          <= 1'b0;
      vlan_valid     <= 1'b0;
      vlan_id        <= '0;
      remote_mac     <= '0;
      frame_cnt      <= '0;
      drop_addr_cnt  <= '0;
      drop_proto_cnt <= '0;
    end else begin
      if (frame_start) begin
        bcast     <= 1'b1;
        ucast     <= 1'b1;
        mcast     <= '1;
        dst_ok    <= 1'b0;
        mcast_hit <= 1'b0;
      end
      if (dst_step) begin
        bcast <= bcast_nxt;
        ucast <= ucast_nxt;
        mcast <= mcast_nxt;
      end
      if (dst_last) begin
        dst_ok    <= accept_nxt;
        mcast_hit <= |(mcast_nxt & mcast_en);
      end
      if (src_step)   temp_mac <= {temp_mac[39:0], data};
      if (type_hi_ld) type_hi <= data;
      if (tci_hi_ld)  vid_tmp[11:8] <= data[3:0];
      if (tci_lo_ld)  vid_tmp[7:0] <= data;
      if (take) begin
        remote_mac <= temp_mac;
        broadcast  <= bcast;
        multicast  <= mcast_hit;
        is_arp     <= (ethertype == 16'h0806);
        is_ip      <= (ethertype == 16'h0800);
        vlan_valid <= (state == S_TYPE2);
        vlan_id    <= (state == S_TYPE2) ? vid_tmp : 12'h000;
        frame_cnt  <= sat_inc(frame_cnt);
      end
      if (drop_addr)  drop_addr_cnt  <= sat_inc(drop_addr_cnt);
      if (drop_proto) drop_proto_cnt <= sat_inc(drop_proto_cnt);
    end
  end

endmodule

// File: tb/tb_mac_recv_filt.sv
// Scoreboard bench for mac_recv_filt: directed frames push expected per-byte active and
// end-of-frame outputs; a negedge monitor pops and compares.
module tb_mac_recv_filt;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic        bc, mc, arp, ip, vv;
    logic [11:0] vid;
    logic [47:0] rm;
    logic [15:0] fc, da, dp;
  } obs_t;

  logic        clock = 1'b0;
  logic        reset_n, rx_enable, promisc, tgt;
  logic [7:0]  data;
  logic [47:0] local_mac;
  logic [95:0] mcast_mac;
  logic [1:0]  mcast_en;
  logic        en_a, en_b;

  logic        act_a, bc_a, mc_a, arp_a, ip_a, vv_a;
  logic [11:0] vid_a;
  logic [47:0] rm_a;
  logic [15:0] fc_a, da_a, dp_a;
  logic        act_b, bc_b, mc_b, arp_b, ip_b, vv_b;
  logic [11:0] vid_b;
  logic [47:0] rm_b;
  logic [3:0]  fc_b, da_b, dp_b;

  int   tests = 0;
  int   fails = 0;
  obs_t exp_q[$];
  string name_q[$];
  logic act_q[$];
  logic prev_en = 1'b0;
  int   byte_idx = 0;

  always #5 clock = ~clock;

  assign en_a = rx_enable & ~tgt;
  assign en_b = rx_enable & tgt;

  mac_recv_filt dut_a (
    .clock(clock), .reset_n(reset_n), .rx_enable(en_a), .data(data),
    .local_mac(local_mac), .mcast_mac(mcast_mac), .mcast_en(mcast_en), .promisc(promisc),
    .active(act_a), .broadcast(bc_a), .multicast(mc_a), .is_arp(arp_a), .is_ip(ip_a),
    .vlan_valid(vv_a), .vlan_id(vid_a), .remote_mac(rm_a), .frame_cnt(fc_a),
    .drop_addr_cnt(da_a), .drop_proto_cnt(dp_a)
  );

  mac_recv_filt #(.NUM_MCAST(2), .VLAN_EN(0), .CNT_W(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .rx_enable(en_b), .data(data),
    .local_mac(local_mac), .mcast_mac(mcast_mac), .mcast_en(mcast_en), .promisc(promisc),
    .active(act_b), .broadcast(bc_b), .multicast(mc_b), .is_arp(arp_b), .is_ip(ip_b),
    .vlan_valid(vv_b), .vlan_id(vid_b), .remote_mac(rm_b), .frame_cnt(fc_b),
    .drop_addr_cnt(da_b), .drop_proto_cnt(dp_b)
  );

  function automatic obs_t observe();
    if (tgt)
      return {bc_b, mc_b, arp_b, ip_b, vv_b, vid_b, rm_b,
              {12'h000, fc_b}, {12'h000, da_b}, {12'h000, dp_b}};
    return {bc_a, mc_a, arp_a, ip_a, vv_a, vid_a, rm_a, fc_a, da_a, dp_a};
  endfunction

  function automatic obs_t ob(logic bc, logic mc, logic arp, logic ip, logic vv,
                              logic [11:0] vid, logic [47:0] rm,
                              logic [15:0] fc, logic [15:0] da, logic [15:0] dp);
    return {bc, mc, arp, ip, vv, vid, rm, fc, da, dp};
  endfunction

  task automatic check_obs(string nm, obs_t exp);
    obs_t got;
    got = observe();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: outputs got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rx_enable) begin
      logic got_act, e;
      got_act = tgt ? act_b : act_a;
      tests++;
      if (act_q.size() == 0) begin
        fails++;
        $display("FAIL active_underflow: got %b expected no byte", got_act);
      end else begin
        e = act_q.pop_front();
        if (got_act !== e) begin
          fails++;
          $display("FAIL active %s byte %0d: got %b expected %b",
                   (name_q.size() > 0) ? name_q[0] : "?", byte_idx, got_act, e);
        end
      end
      byte_idx <= byte_idx + 1;
    end else if (prev_en) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL frame_underflow: got frame end expected none");
      end else begin
        check_obs(name_q.pop_front(), exp_q.pop_front());
      end
      byte_idx <= 0;
    end
    prev_en <= rx_enable;
  end

  function automatic byte_q_t mk(logic [47:0] dst, logic [47:0] src, logic [15:0] et);
    byte_q_t q;
    for (int i = 5; i >= 0; i--) q.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) q.push_back(src[8*i +: 8]);
    q.push_back(et[15:8]);
    q.push_back(et[7:0]);
    return q;
  endfunction

  task automatic send(string nm, input byte_q_t hdr, input int pay_len,
                      input int act_from, input int rst_at, input obs_t exp);
    int total;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    total = hdr.size() + pay_len;
    for (int i = 0; i < total; i++) begin
      logic e;
      e = (act_from >= 0) && (i >= act_from) && (rst_at < 0 || i < rst_at);
      act_q.push_back(e);
      if (i == rst_at) reset_n = 1'b0;
      rx_enable = 1'b1;
      data = (i < hdr.size()) ? hdr[i] : 8'(8'hA0 + i);
      @(posedge clock); #1;
      if (i == rst_at) reset_n = 1'b1;
    end
    rx_enable = 1'b0;
    data = 8'h00;
    repeat (3) @(posedge clock);
    #1;
  endtask

  localparam logic [47:0] LMAC = 48'h001CC0A213DD;
  localparam logic [47:0] BMAC = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] MMAC = 48'h01005E0000FB;

  initial begin
    byte_q_t h;
    reset_n   = 1'b0;
    rx_enable = 1'b0;
    tgt       = 1'b0;
    promisc   = 1'b0;
    mcast_en  = 2'b00;
    data      = 8'h00;
    local_mac = LMAC;
    mcast_mac = {MMAC, 48'h01005E000001};
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    check_obs("reset", '0);
    repeat (2) @(posedge clock);
    #1;

    send("ucast_ip", mk(LMAC, 48'h112233445566, 16'h0800), 4, 14, -1,
         ob(0, 0, 0, 1, 0, 12'h0, 48'h112233445566, 1, 0, 0));
    send("bcast_arp", mk(BMAC, 48'hAABBCCDDEEFF, 16'h0806), 4, 14, -1,
         ob(1, 0, 1, 0, 0, 12'h0, 48'hAABBCCDDEEFF, 2, 0, 0));
    send("addr_drop", mk(48'h000000000001, 48'h010203040506, 16'h0800), 4, -1, -1,
         ob(1, 0, 1, 0, 0, 12'h0, 48'hAABBCCDDEEFF, 2, 1, 0));

    mcast_en = 2'b10;
    send("mcast_hit", mk(MMAC, 48'h0A0B0C0D0E0F, 16'h0800), 4, 14, -1,
         ob(0, 1, 0, 1, 0, 12'h0, 48'h0A0B0C0D0E0F, 3, 1, 0));
    mcast_en = 2'b00;
    send("mcast_off", mk(MMAC, 48'h0A0B0C0D0E0F, 16'h0800), 4, -1, -1,
         ob(0, 1, 0, 1, 0, 12'h0, 48'h0A0B0C0D0E0F, 3, 2, 0));
    promisc = 1'b1;
    send("promisc", mk(MMAC, 48'h1A1B1C1D1E1F, 16'h0800), 4, 14, -1,
         ob(0, 0, 0, 1, 0, 12'h0, 48'h1A1B1C1D1E1F, 4, 2, 0));
    promisc = 1'b0;
    mcast_en = 2'b10;
    send("slot0_disabled", mk(48'h01005E000001, 48'h1A1B1C1D1E20, 16'h0800), 4, -1, -1,
         ob(0, 0, 0, 1, 0, 12'h0, 48'h1A1B1C1D1E1F, 4, 3, 0));
    mcast_en = 2'b00;

    h = mk(LMAC, 48'h112233445566, 16'h8100);
    h.push_back(8'h20); h.push_back(8'h64); h.push_back(8'h08); h.push_back(8'h00);
    send("vlan_ip", h, 4, 18, -1,
         ob(0, 0, 0, 1, 1, 12'h064, 48'h112233445566, 5, 3, 0));
    h = mk(LMAC, 48'h665544332211, 16'h8100);
    h.push_back(8'h00); h.push_back(8'h01); h.push_back(8'h81); h.push_back(8'h00);
    send("vlan_stacked", h, 4, -1, -1,
         ob(0, 0, 0, 1, 1, 12'h064, 48'h112233445566, 5, 3, 1));
    send("ipv6_drop", mk(LMAC, 48'h665544332211, 16'h86DD), 4, -1, -1,
         ob(0, 0, 0, 1, 1, 12'h064, 48'h112233445566, 5, 3, 2));

    tgt = 1'b1;
    h = mk(LMAC, 48'h112233445566, 16'h8100);
    h.push_back(8'h20); h.push_back(8'h64); h.push_back(8'h08); h.push_back(8'h00);
    send("novlan_drop", h, 2, -1, -1, ob(0, 0, 0, 0, 0, 12'h0, 48'h0, 0, 0, 1));
    for (int k = 0; k < 20; k++) begin
      send("sat_drop", mk(LMAC, 48'h665544332211, 16'h86DD), 2, -1, -1,
           ob(0, 0, 0, 0, 0, 12'h0, 48'h0, 0, 0, (k + 2 > 15) ? 16'd15 : 16'(k + 2)));
    end
    send("small_arp", mk(LMAC, 48'h0C0D0E0F1011, 16'h0806), 3, 14, -1,
         ob(0, 0, 1, 0, 0, 12'h0, 48'h0C0D0E0F1011, 1, 0, 15));
    tgt = 1'b0;

    send("reset_mid", mk(LMAC, 48'h223344556677, 16'h0800), 10, 14, 16, '0);
    send("after_reset", mk(LMAC, 48'h112233445566, 16'h0800), 4, 14, -1,
         ob(0, 0, 0, 1, 0, 12'h0, 48'h112233445566, 1, 0, 0));
    h = mk(LMAC, 48'h998877665544, 16'h0800);
    while (h.size() > 10) void'(h.pop_back());
    send("truncated", h, 0, -1, -1,
         ob(0, 0, 0, 1, 0, 12'h0, 48'h112233445566, 1, 0, 0));
    send("after_trunc", mk(BMAC, 48'hAABBCCDDEEFF, 16'h0806), 4, 14, -1,
         ob(1, 0, 1, 0, 0, 12'h0, 48'hAABBCCDDEEFF, 2, 0, 0));

    repeat (5) @(posedge clock);
    #1;
    tests++;
    if (exp_q.size() != 0 || act_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d frames %0d bytes pending expected 0",
               exp_q.size(), act_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
